// File: rtl/avalon_csr_pkg.sv
// Shared types and constants for the multi-channel Avalon-MM to CSR bridge.
package avalon_csr_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_BURST = 2'd1,
        RD_ISSUE = 2'd2,
        RD_DRAIN = 2'd3
    } state_e;

    localparam int          ERR_CNT_W        = 16;
    localparam logic [31:0] BAD_DATA_DEFAULT = 32'hDEAD_BEEF;

    // Smallest channel-select width that can address ch_cnt channels.
    function automatic int ch_sel_w(input int ch_cnt);
        if (ch_cnt <= 2) begin
            return 1;
        end else begin
            return $clog2(ch_cnt);
        end
    endfunction

endpackage

// File: rtl/csr_rd_pipe.sv
// Fixed-latency tag pipe that tracks outstanding CSR read beats.
// Each stage carries {valid, channel, bad}.
module csr_rd_pipe #(
    parameter int DEPTH = 2,
    parameter int CH_W  = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            squash,
    input  logic            push,
    input  logic [CH_W-1:0] push_ch,
    input  logic            push_bad,
    output logic            out_valid,
    output logic [CH_W-1:0] out_ch,
    output logic            out_bad,
    output logic            empty
);

    logic [DEPTH-1:0] valid_r;
    logic [DEPTH-1:0] bad_r;
    logic [CH_W-1:0]  ch_r [DEPTH];

    // Shift register; squash drops every in-flight beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r <= {DEPTH{1'b0}};
            bad_r   <= {DEPTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                ch_r[i] <= {CH_W{1'b0}};
            end
        end else if (squash) begin
            valid_r <= {DEPTH{1'b0}};
            bad_r   <= {DEPTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                ch_r[i] <= {CH_W{1'b0}};
            end
        end else begin
            valid_r[0] <= push;
            bad_r[0]   <= push_bad;
            ch_r[0]    <= push_ch;
            for (int i = 1; i < DEPTH; i++) begin
                valid_r[i] <= valid_r[i-1];
                bad_r[i]   <= bad_r[i-1];
                ch_r[i]    <= ch_r[i-1];
            end
        end
    end

    assign out_valid = valid_r[DEPTH-1];
    assign out_ch    = ch_r[DEPTH-1];
    assign out_bad   = bad_r[DEPTH-1];
    assign empty     = ~|valid_r;

endmodule

// File: rtl/avalon_mm_to_csr_mux.sv
// Avalon-MM agent that decodes upper address bits onto CH_CNT CSR channels,
// with burst reads/writes, byteenable forwarding and decode-error reporting.
module avalon_mm_to_csr_mux
    import avalon_csr_pkg::*;
#(
    parameter int                DATA_W     = 32,
    parameter int                CH_CNT     = 4,
    parameter int                CH_SEL_W   = ch_sel_w(CH_CNT),
    parameter int                CH_ADDR_W  = 8,
    parameter int                BURST_W    = 4,
    parameter int                RD_LATENCY = 1,
    parameter logic [DATA_W-1:0] BAD_DATA   = DATA_W'(BAD_DATA_DEFAULT)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    output logic                          amm_waitrequest_o,
    output logic [DATA_W-1:0]             amm_readdata_o,
    output logic                          amm_readdatavalid_o,
    input  logic [BURST_W-1:0]            amm_burstcount_i,
    input  logic [DATA_W-1:0]             amm_writedata_i,
    input  logic [CH_SEL_W+CH_ADDR_W-1:0] amm_address_i,
    input  logic                          amm_write_i,
    input  logic                          amm_read_i,
    input  logic [DATA_W/8-1:0]           amm_byteenable_i,
    input  logic                          amm_debugaccess_i,
    output logic [CH_ADDR_W-1:0]          csr_address_o,
    output logic [DATA_W-1:0]             csr_writedata_o,
    output logic [DATA_W/8-1:0]           csr_byteenable_o,
    output logic [CH_CNT-1:0]             csr_write_o,
    output logic [CH_CNT-1:0]             csr_read_o,
    input  logic [CH_CNT*DATA_W-1:0]      csr_readdata_i,
    output logic [ERR_CNT_W-1:0]          err_cnt_o
);

    localparam int ADDR_W = CH_SEL_W + CH_ADDR_W;
    localparam int BE_W   = DATA_W / 8;

    function automatic logic [CH_CNT-1:0] ch_onehot(input logic [CH_SEL_W-1:0] ch);
        logic [CH_CNT-1:0] oh;
        for (int k = 0; k < CH_CNT; k++) begin
            oh[k] = (CH_SEL_W'(k) == ch);
        end
        return oh;
    endfunction

    state_e                 state_r, state_s;
    logic [CH_ADDR_W-1:0]   addr_r, addr_s, beat_addr_s;
    logic [CH_SEL_W-1:0]    ch_r, ch_s, push_ch_s;
    logic                   bad_r, bad_s, push_bad_s;
    logic [BURST_W-1:0]     rem_r, rem_s, burst_s;
    logic [CH_CNT-1:0]      wr_strobe_s, rd_strobe_s, csr_write_r, csr_read_r;
    logic                   beat_s, push_s, err_inc_s, waitreq_s, waitreq_r;
    logic [CH_ADDR_W-1:0]   csr_addr_r;
    logic [DATA_W-1:0]      csr_wdata_r, rd_mux_s, rdata_r;
    logic [BE_W-1:0]        csr_be_r;
    logic                   rvalid_r;
    logic [ERR_CNT_W-1:0]   err_cnt_r;
    logic [CH_SEL_W-1:0]    cmd_ch_s;
    logic [CH_ADDR_W-1:0]   cmd_addr_s;
    logic                   cmd_bad_s;
    logic                   pipe_valid_s, pipe_bad_s, pipe_empty_s;
    logic [CH_SEL_W-1:0]    pipe_ch_s;
    logic                   unused_s;

    assign unused_s   = amm_debugaccess_i;
    assign cmd_ch_s   = amm_address_i[ADDR_W-1 -: CH_SEL_W];
    assign cmd_addr_s = amm_address_i[CH_ADDR_W-1:0];
    assign cmd_bad_s  = (int'(cmd_ch_s) >= CH_CNT);
    assign burst_s    = (amm_burstcount_i == {BURST_W{1'b0}}) ? BURST_W'(1) : amm_burstcount_i;

    // Next-state, beat issue and error decisions.
    always_comb begin
        state_s     = state_r;
        addr_s      = addr_r;
        ch_s        = ch_r;
        bad_s       = bad_r;
        rem_s       = rem_r;
        wr_strobe_s = {CH_CNT{1'b0}};
        rd_strobe_s = {CH_CNT{1'b0}};
        beat_s      = 1'b0;
        beat_addr_s = addr_r;
        push_s      = 1'b0;
        push_ch_s   = ch_r;
        push_bad_s  = bad_r;
        err_inc_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (!waitreq_r && amm_write_i) begin
                    // A simultaneous read is dropped and reported as an error.
                    beat_s      = 1'b1;
                    beat_addr_s = cmd_addr_s;
                    wr_strobe_s = cmd_bad_s ? {CH_CNT{1'b0}} : ch_onehot(cmd_ch_s);
                    ch_s        = cmd_ch_s;
                    bad_s       = cmd_bad_s;
                    addr_s      = cmd_addr_s + CH_ADDR_W'(1);
                    rem_s       = burst_s - BURST_W'(1);
                    err_inc_s   = cmd_bad_s | amm_read_i;
                    if (burst_s > BURST_W'(1)) begin
                        state_s = WR_BURST;
                    end else begin
                        state_s = IDLE;
                    end
                end else if (!waitreq_r && amm_read_i) begin
                    beat_s      = 1'b1;
                    beat_addr_s = cmd_addr_s;
                    rd_strobe_s = cmd_bad_s ? {CH_CNT{1'b0}} : ch_onehot(cmd_ch_s);
                    push_s      = 1'b1;
                    push_ch_s   = cmd_ch_s;
                    push_bad_s  = cmd_bad_s;
                    ch_s        = cmd_ch_s;
                    bad_s       = cmd_bad_s;
                    addr_s      = cmd_addr_s + CH_ADDR_W'(1);
                    rem_s       = burst_s - BURST_W'(1);
                    err_inc_s   = cmd_bad_s;
                    state_s     = RD_ISSUE;
                end else begin
                    state_s = IDLE;
                end
            end
            WR_BURST: begin
                if (amm_write_i) begin
                    beat_s      = 1'b1;
                    wr_strobe_s = bad_r ? {CH_CNT{1'b0}} : ch_onehot(ch_r);
                    addr_s      = addr_r + CH_ADDR_W'(1);
                    rem_s       = rem_r - BURST_W'(1);
                    if (rem_r == BURST_W'(1)) begin
                        state_s = IDLE;
                    end else begin
                        state_s = WR_BURST;
                    end
                end else begin
                    state_s = WR_BURST;
                end
            end
            RD_ISSUE: begin
                if (rem_r == {BURST_W{1'b0}}) begin
                    state_s = RD_DRAIN;
                end else begin
                    beat_s      = 1'b1;
                    rd_strobe_s = bad_r ? {CH_CNT{1'b0}} : ch_onehot(ch_r);
                    push_s      = 1'b1;
                    addr_s      = addr_r + CH_ADDR_W'(1);
                    rem_s       = rem_r - BURST_W'(1);
                    if (rem_r == BURST_W'(1)) begin
                        state_s = RD_DRAIN;
                    end else begin
                        state_s = RD_ISSUE;
                    end
                end
            end
            RD_DRAIN: begin
                if (pipe_empty_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = RD_DRAIN;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        waitreq_s = (state_s == RD_ISSUE) || (state_s == RD_DRAIN);
    end

    // Command-tracking state and waitrequest.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r   <= IDLE;
            addr_r    <= {CH_ADDR_W{1'b0}};
            ch_r      <= {CH_SEL_W{1'b0}};
            bad_r     <= 1'b0;
            rem_r     <= {BURST_W{1'b0}};
            waitreq_r <= 1'b1;
        end else begin
            state_r   <= state_s;
            addr_r    <= addr_s;
            ch_r      <= ch_s;
            bad_r     <= bad_s;
            rem_r     <= rem_s;
            waitreq_r <= waitreq_s;
        end
    end

    // Registered CSR-side beat outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            csr_write_r <= {CH_CNT{1'b0}};
            csr_read_r  <= {CH_CNT{1'b0}};
            csr_addr_r  <= {CH_ADDR_W{1'b0}};
            csr_wdata_r <= {DATA_W{1'b0}};
            csr_be_r    <= {BE_W{1'b0}};
        end else begin
            csr_write_r <= wr_strobe_s;
            csr_read_r  <= rd_strobe_s;
            if (beat_s) begin
                csr_addr_r  <= beat_addr_s;
                csr_wdata_r <= amm_writedata_i;
                csr_be_r    <= amm_byteenable_i;
            end
        end
    end

    // Saturating decode-error counter, one step per command.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_cnt_r <= {ERR_CNT_W{1'b0}};
        end else if (err_inc_s && (err_cnt_r != {ERR_CNT_W{1'b1}})) begin
            err_cnt_r <= err_cnt_r + ERR_CNT_W'(1);
        end
    end

    csr_rd_pipe #(
        .DEPTH (RD_LATENCY + 1),
        .CH_W  (CH_SEL_W)
    ) u_rd_pipe (
        .clk       (clk_i),
        .rst       (rst_i),
        .squash    (rst_i),
        .push      (push_s),
        .push_ch   (push_ch_s),
        .push_bad  (push_bad_s),
        .out_valid (pipe_valid_s),
        .out_ch    (pipe_ch_s),
        .out_bad   (pipe_bad_s),
        .empty     (pipe_empty_s)
    );

    // Select the channel tagged by the beat leaving the pipe.
    always_comb begin
        rd_mux_s = {DATA_W{1'b0}};
        for (int k = 0; k < CH_CNT; k++) begin
            rd_mux_s = (CH_SEL_W'(k) == pipe_ch_s) ? csr_readdata_i[k*DATA_W +: DATA_W] : rd_mux_s;
        end
    end

    // Registered Avalon read return.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rvalid_r <= 1'b0;
            rdata_r  <= {DATA_W{1'b0}};
        end else begin
            rvalid_r <= pipe_valid_s;
            if (pipe_valid_s) begin
                rdata_r <= pipe_bad_s ? BAD_DATA : rd_mux_s;
            end
        end
    end

    assign amm_waitrequest_o   = waitreq_r;
    assign amm_readdata_o      = rdata_r;
    assign amm_readdatavalid_o = rvalid_r;
    assign csr_address_o       = csr_addr_r;
    assign csr_writedata_o     = csr_wdata_r;
    assign csr_byteenable_o    = csr_be_r;
    assign csr_write_o         = csr_write_r;
    assign csr_read_o          = csr_read_r;
    assign err_cnt_o           = err_cnt_r;

endmodule

// File: tb/tb_avalon_mm_to_csr_mux.sv
// Scoreboard bench for avalon_mm_to_csr_mux: 3 channels (channel 3 decodes as error),
// read latency 2, CSR read data modelled as a function of channel and address.
module tb_avalon_mm_to_csr_mux;

    localparam int DATA_W = 32;
    localparam int CH_CNT = 3;
    localparam int CH_SEL_W = 2;
    localparam int CH_ADDR_W = 8;
    localparam int BURST_W = 4;
    localparam int RD_LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wait_o, rvalid_o;
    logic [31:0] rdata_o;
    logic [3:0]  burst = 4'd0;
    logic [31:0] wdata = 32'h0;
    logic [9:0]  address = 10'h0;
    logic        write = 1'b0, read = 1'b0, dbg = 1'b0;
    logic [3:0]  be = 4'h0;
    logic [7:0]  caddr_o;
    logic [31:0] cwdata_o;
    logic [3:0]  cbe_o;
    logic [2:0]  cwr_o, crd_o;
    logic [95:0] crdata;
    logic [15:0] err_o;
    logic [7:0]  addr_d1 = 8'h0, addr_d2 = 8'h0;
    int          cyc = 0;
    int          total = 0;
    int          passed = 0;

    typedef struct { logic [2:0] strobe; logic [7:0] addr; logic [31:0] data; logic [3:0] be; int cyc; } wr_exp_t;
    typedef struct { logic [2:0] strobe; logic [7:0] addr; int cyc; } rd_exp_t;
    typedef struct { logic [31:0] data; int cyc; } rdata_exp_t;

    wr_exp_t    exp_wr[$];
    rd_exp_t    exp_rd[$];
    rdata_exp_t exp_rdata[$];
    wr_exp_t    got_wr;
    rd_exp_t    got_rd;
    rdata_exp_t got_rdata;

    avalon_mm_to_csr_mux #(
        .DATA_W     (DATA_W),
        .CH_CNT     (CH_CNT),
        .CH_SEL_W   (CH_SEL_W),
        .CH_ADDR_W  (CH_ADDR_W),
        .BURST_W    (BURST_W),
        .RD_LATENCY (RD_LAT),
        .BAD_DATA   (32'hDEAD_BEEF)
    ) dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .amm_waitrequest_o   (wait_o),
        .amm_readdata_o      (rdata_o),
        .amm_readdatavalid_o (rvalid_o),
        .amm_burstcount_i    (burst),
        .amm_writedata_i     (wdata),
        .amm_address_i       (address),
        .amm_write_i         (write),
        .amm_read_i          (read),
        .amm_byteenable_i    (be),
        .amm_debugaccess_i   (dbg),
        .csr_address_o       (caddr_o),
        .csr_writedata_o     (cwdata_o),
        .csr_byteenable_o    (cbe_o),
        .csr_write_o         (cwr_o),
        .csr_read_o          (crd_o),
        .csr_readdata_i      (crdata),
        .err_cnt_o           (err_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        addr_d1 <= caddr_o;
        addr_d2 <= addr_d1;
    end

    function automatic logic [31:0] exp_data(input int ch, input logic [7:0] a);
        return {4'hC, 4'(ch), 16'h0000, a};
    endfunction

    // CSR register files answer RD_LAT cycles after the strobe.
    always_comb begin
        crdata = 96'h0;
        for (int k = 0; k < CH_CNT; k++) begin
            crdata[k*32 +: 32] = exp_data(k, addr_d2);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: pop and compare whenever the DUT presents a strobe or a read beat.
    always @(negedge clk) begin
        if (!rst) begin
            if (cwr_o != 3'b000) begin
                if (exp_wr.size() == 0) check("wr_unexpected", 64'(cwr_o), 64'h0);
                else begin
                    got_wr = exp_wr.pop_front();
                    check("wr_strobe", 64'(cwr_o), 64'(got_wr.strobe));
                    check("wr_addr", 64'(caddr_o), 64'(got_wr.addr));
                    check("wr_data", 64'(cwdata_o), 64'(got_wr.data));
                    check("wr_be", 64'(cbe_o), 64'(got_wr.be));
                    check("wr_cycle", 64'(cyc), 64'(got_wr.cyc));
                end
            end
            if (crd_o != 3'b000) begin
                if (exp_rd.size() == 0) check("rd_unexpected", 64'(crd_o), 64'h0);
                else begin
                    got_rd = exp_rd.pop_front();
                    check("rd_strobe", 64'(crd_o), 64'(got_rd.strobe));
                    check("rd_addr", 64'(caddr_o), 64'(got_rd.addr));
                    check("rd_cycle", 64'(cyc), 64'(got_rd.cyc));
                end
            end
            if (rvalid_o) begin
                if (exp_rdata.size() == 0) check("rvalid_unexpected", 64'(rvalid_o), 64'h0);
                else begin
                    got_rdata = exp_rdata.pop_front();
                    check("rdata", 64'(rdata_o), 64'(got_rdata.data));
                    check("rdata_cycle", 64'(cyc), 64'(got_rdata.cyc));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (wait_o && n < 40) begin
            tick();
            n++;
        end
        check("wait_idle_timeout", 64'(wait_o), 64'h0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_waitreq"}, 64'(wait_o), 64'h1);
        check({tag, "_rvalid"}, 64'(rvalid_o), 64'h0);
        check({tag, "_rdata"}, 64'(rdata_o), 64'h0);
        check({tag, "_csr_write"}, 64'(cwr_o), 64'h0);
        check({tag, "_csr_read"}, 64'(crd_o), 64'h0);
        check({tag, "_csr_addr"}, 64'(caddr_o), 64'h0);
        check({tag, "_csr_wdata"}, 64'(cwdata_o), 64'h0);
        check({tag, "_csr_be"}, 64'(cbe_o), 64'h0);
        check({tag, "_err_cnt"}, 64'(err_o), 64'h0);
    endtask

    initial begin
        int t;
        logic [7:0] a;
        repeat (3) tick();
        check_reset_values("por");
        rst = 1'b0;
        wait_idle();

        // Test 1: single write (burstcount 0 means 1) to channel 2.
        check("t1_waitreq", 64'(wait_o), 64'h0);
        address = {2'd2, 8'h10}; wdata = 32'hA5A5_0001; be = 4'b0011; burst = 4'd0; write = 1'b1;
        exp_wr.push_back('{3'b100, 8'h10, 32'hA5A5_0001, 4'b0011, cyc + 1});
        tick();
        write = 1'b0;
        repeat (4) tick();

        // Test 2: read burst of 4 from channel 1 wrapping at 0xFF.
        t = cyc;
        address = {2'd1, 8'hFE}; burst = 4'd4; be = 4'hF; read = 1'b1;
        for (int k = 0; k < 4; k++) begin
            a = 8'hFE + 8'(k);
            exp_rd.push_back('{3'b010, a, t + 1 + k});
            exp_rdata.push_back('{exp_data(1, a), t + 4 + k});
        end
        tick();
        read = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            check("t2_waitreq", 64'(wait_o), 64'(i <= 7));
            tick();
        end

        // Test 3: write burst of 3 with a two-cycle stall before beat 2.
        address = {2'd0, 8'h20}; burst = 4'd3; be = 4'hF; wdata = 32'h1111_0000; write = 1'b1;
        exp_wr.push_back('{3'b001, 8'h20, 32'h1111_0000, 4'hF, cyc + 1});
        tick();
        check("t3_waitreq", 64'(wait_o), 64'h0);
        wdata = 32'h1111_0001;
        exp_wr.push_back('{3'b001, 8'h21, 32'h1111_0001, 4'hF, cyc + 1});
        tick();
        write = 1'b0;
        repeat (2) begin
            check("t3_stall_waitreq", 64'(wait_o), 64'h0);
            tick();
        end
        wdata = 32'h1111_0002; write = 1'b1;
        exp_wr.push_back('{3'b001, 8'h22, 32'h1111_0002, 4'hF, cyc + 1});
        tick();
        write = 1'b0;
        repeat (4) tick();

        // Test 4: read burst of 2 at channel 3, which does not exist.
        check("t4_err_before", 64'(err_o), 64'h0);
        t = cyc;
        address = {2'd3, 8'h05}; burst = 4'd2; read = 1'b1;
        exp_rdata.push_back('{32'hDEAD_BEEF, t + 4});
        exp_rdata.push_back('{32'hDEAD_BEEF, t + 5});
        tick();
        read = 1'b0;
        wait_idle();
        check("t4_err_after", 64'(err_o), 64'h1);

        // Test 5: write and read together; write wins, read dropped as an error.
        address = {2'd1, 8'h33}; wdata = 32'h5555_AAAA; be = 4'b1111; burst = 4'd1;
        write = 1'b1; read = 1'b1;
        exp_wr.push_back('{3'b010, 8'h33, 32'h5555_AAAA, 4'b1111, cyc + 1});
        tick();
        write = 1'b0; read = 1'b0;
        repeat (5) tick();
        check("t5_err", 64'(err_o), 64'h2);
        check("t5_waitreq", 64'(wait_o), 64'h0);

        // Test 6: reset during beat 2 of a 4-beat read, then a fresh read.
        t = cyc;
        address = {2'd0, 8'h40}; burst = 4'd4; read = 1'b1;
        exp_rd.push_back('{3'b001, 8'h40, t + 1});
        exp_rd.push_back('{3'b001, 8'h41, t + 2});
        tick();
        read = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        check_reset_values("mid_rst");
        tick();
        tick();
        rst = 1'b0;
        wait_idle();
        repeat (6) tick();
        t = cyc;
        address = {2'd2, 8'h07}; burst = 4'd1; read = 1'b1;
        exp_rd.push_back('{3'b100, 8'h07, t + 1});
        exp_rdata.push_back('{exp_data(2, 8'h07), t + 4});
        tick();
        read = 1'b0;
        wait_idle();
        repeat (3) tick();

        check("exp_wr_drained", 64'(exp_wr.size()), 64'h0);
        check("exp_rd_drained", 64'(exp_rd.size()), 64'h0);
        check("exp_rdata_drained", 64'(exp_rdata.size()), 64'h0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
